data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-memory responder for the pipelined CPU's MEM stage. It answers the CPU's mrd/mwrt requests (address from ALUout, write data from RT_Reg) with a configurable wait-state latency.
- Returns DataRead plus a one-cycle Ack, and raises Stall so the pipeline freezes while an access is outstanding.
- Word-addressed, single-ported, one access in flight.

Parameters:
- ADDR_BITS, 8, memory depth is 2**ADDR_BITS 32-bit words
- WAIT_STATES, 2, cycles spent in WAIT before the access completes (0..15)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- mrd  in  1  read request, level, held until Ack
- mwrt  in  1  write request, level, held until Ack
- Addr  in  32  word address (CPU ALUout)
- DataIn  in  32  write data (CPU RT_Reg)
- DataRead  out  32  read data, registered
- Ack  out  1  access-complete pulse, registered
- Stall  out  1  combinational: (mrd|mwrt) & ~Ack
- Busy  out  1  registered: state != IDLE
- Err  out  1  registered one-cycle pulse on an illegal request

Behaviour:
- Clock is Clock. Reset is asynchronous, active-high.
- Reset values: state=IDLE, cnt=0, DataRead=0, Ack=0, Err=0, Busy=0. Memory array is not reset.
- States:
  - IDLE
  - WAIT (counter cnt)
  - RESP (Ack=1 for exactly this cycle)
- Request sampling:
  - A request (mrd|mwrt) is sampled at a rising edge while state is IDLE or RESP.
  - On sampling, latch op, Addr and DataIn.
  - Next state is WAIT with cnt=WAIT_STATES-1 if WAIT_STATES>0; otherwise RESP directly.
- WAIT: cnt decrements each edge. At the edge where cnt==0, the access is performed and state becomes RESP.
- Access, performed at the edge entering RESP:
  - Write: mem[Addr[ADDR_BITS-1:0]] <= latched DataIn. DataRead unchanged.
  - Read: DataRead <= mem[Addr[ADDR_BITS-1:0]].
- Latency: request sampled at edge N → Ack high in the cycle after edge N+WAIT_STATES. Read data is valid in that same cycle and is held until the next read completes.
- RESP → WAIT/RESP if a new request is present at the edge ending RESP (back-to-back); otherwise → IDLE.
  - The requester must drop mrd/mwrt during the Ack cycle if it has no further access.
  - A request still high at that edge is treated as a new access.
- Simultaneous mrd & mwrt:
  - Treated as a write.
  - Err pulses in the RESP cycle of that access.
- Out-of-range address (Addr[31:ADDR_BITS] != 0):
  - No memory write.
  - Reads return 0 into DataRead.
  - Ack still completes normally; Err pulses with Ack.
- Requests arriving in WAIT are ignored. Latched values are used and the inputs are not re-sampled.
- Reset asserted mid-access (WAIT or RESP):
  - Immediate return to IDLE, outputs go to reset values.
  - A pending write not yet committed is discarded.
  - Memory contents already written persist.
- Stall follows its combinational equation in every state, including reset (Ack=0 → Stall=mrd|mwrt).

Test Plan:
- WAIT_STATES=2: mwrt at Addr=0x5, DataIn=0xDEADBEEF sampled at edge N.
  - → Ack high only in the cycle after edge N+2; Stall high cycles N..N+2.
  - Then mrd Addr=0x5 → DataRead=0xDEADBEEF with its Ack.
- Back-to-back: hold mwrt (Addr=0x1, 0x11111111) through Ack, then switch to mrd Addr=0x1 during the Ack cycle.
  - → second Ack exactly WAIT_STATES+1 cycles after the first; DataRead=0x11111111; Busy never drops between them.
- Reset mid-WAIT of a write (Addr=0x7, 0xCAFEF00D) after a prior write of 0x12345678 to 0x7.
  - → Busy/Ack/DataRead cleared immediately.
  - Subsequent read of 0x7 returns 0x12345678.
- mrd=1 and mwrt=1 together, Addr=0x3, DataIn=0xA5A5A5A5.
  - → Err and Ack high in the same cycle.
  - Following read of 0x3 returns 0xA5A5A5A5.
- Out-of-range: mwrt at Addr=0x100 (ADDR_BITS=8), then mrd at 0x100 and mrd at 0x000.
  - → Err pulses on both out-of-range Acks; 0x100 read gives DataRead=0.
  - mem[0] unchanged.
- Instance with WAIT_STATES=0: mrd at edge N → Ack in cycle after edge N; Busy high one cycle. Stall high only in cycle N-1..N before Ack.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage data memory responder with configurable wait states.
// One access in flight; Ack/DataRead/Err registered, Stall combinational.
module data_mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        mrd,
  input  logic        mwrt,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataRead,
  output logic        Ack,
  output logic        Stall,
  output logic        Busy,
  output logic        Err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        lat_wr, lat_both;
  logic [31:0] lat_addr, lat_data;

  logic        req, sample, fire;
  logic        acc_wr, acc_both, acc_oor;
  logic [31:0] acc_addr, acc_data;
  logic [ADDR_BITS-1:0] idx;

  logic [31:0] mem [2**ADDR_BITS];

  assign req   = mrd | mwrt;
  assign Stall = req & ~Ack;

  // With zero wait states the access happens on the sampling edge, so it
  // uses the live request inputs instead of the latched copies.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sample   = 1'b0;
    fire     = 1'b0;
    acc_wr   = lat_wr;
    acc_both = lat_both;
    acc_addr = lat_addr;
    acc_data = lat_data;
    case (state)
      IDLE, RESP: begin
        state_nx = IDLE;
        if (req) begin
          sample = 1'b1;
          if (WAIT_STATES == 0) begin
            fire     = 1'b1;
            acc_wr   = mwrt;
            acc_both = mrd & mwrt;
            acc_addr = Addr;
            acc_data = DataIn;
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          fire     = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign acc_oor = (acc_addr >> ADDR_BITS) != 32'd0;
  assign idx     = acc_addr[ADDR_BITS-1:0];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      lat_wr   <= 1'b0;
      lat_both <= 1'b0;
      lat_addr <= 32'd0;
      lat_data <= 32'd0;
      DataRead <= 32'd0;
      Ack      <= 1'b0;
      Busy     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (sample) begin
        lat_wr   <= mwrt;
        lat_both <= mrd & mwrt;
        lat_addr <= Addr;
        lat_data <= DataIn;
      end
      if (fire && !acc_wr)
        DataRead <= acc_oor ? 32'd0 : mem[idx];
      Ack  <= (state_nx == RESP);
      Busy <= (state_nx != IDLE);
      Err  <= fire & (acc_both | acc_oor);
    end
  end

  // Gated by Reset so a commit coinciding with reset assertion is dropped.
  always_ff @(posedge Clock) begin
    if (!Reset && fire && acc_wr && !acc_oor)
      mem[idx] <= acc_data;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (WAIT_STATES=2 and 0).
module tb_data_mem_responder;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  logic        mrd0, mwrt0, mrd1, mwrt1;
  logic [31:0] addr0, din0, addr1, din1;
  logic [31:0] dr0, dr1;
  logic        ack0, stall0, busy0, err0;
  logic        ack1, stall1, busy1, err1;

  data_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(2)) u0 (
    .Clock(Clock), .Reset(Reset), .mrd(mrd0), .mwrt(mwrt0), .Addr(addr0), .DataIn(din0),
    .DataRead(dr0), .Ack(ack0), .Stall(stall0), .Busy(busy0), .Err(err0));

  data_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) u1 (
    .Clock(Clock), .Reset(Reset), .mrd(mrd1), .mwrt(mwrt1), .Addr(addr1), .DataIn(din1),
    .DataRead(dr1), .Ack(ack1), .Stall(stall1), .Busy(busy1), .Err(err1));

  typedef struct {
    int          cyc;
    logic        chk_data;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: one per instance, pop an expectation on every Ack.
  always @(negedge Clock) begin
    exp_t e;
    if (ack0) begin
      if (q0.size() == 0) check("ack0_unexpected", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("ack0_cycle", cyc, e.cyc);
        if (e.chk_data) check("data0", dr0, e.data);
        check("err0", {31'd0, err0}, {31'd0, e.err});
      end
    end else if (err0) check("err0_without_ack", 32'd1, 32'd0);
  end

  always @(negedge Clock) begin
    exp_t e;
    if (ack1) begin
      if (q1.size() == 0) check("ack1_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("ack1_cycle", cyc, e.cyc);
        if (e.chk_data) check("data1", dr1, e.data);
        check("err1", {31'd0, err1}, {31'd0, e.err});
      end
    end else if (err1) check("err1_without_ack", 32'd1, 32'd0);
  end

  task automatic wait_ack(input int which, input int exp_stall, input logic chk_busy);
    int st;
    logic got;
    st = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clock);
      if ((which == 0) ? ack0 : ack1) got = 1'b1;
      else begin
        if ((which == 0) ? stall0 : stall1) st++;
        if (chk_busy) check("busy_held", {31'd0, busy0}, 32'd1);
      end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    else begin
      check("stall_at_ack", {31'd0, (which == 0) ? stall0 : stall1}, 32'd0);
      check("stall_cycles", st, exp_stall);
    end
  endtask

  task automatic access0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic cd, input logic [31:0] ed, input logic ee);
    q0.push_back('{cyc + 3, cd, ed, ee});
    mrd0 = r; mwrt0 = w; addr0 = a; din0 = d;
    wait_ack(0, 3, 1'b0);
    #1 mrd0 = 1'b0; mwrt0 = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic access1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic cd, input logic [31:0] ed, input logic ee);
    q1.push_back('{cyc + 1, cd, ed, ee});
    mrd1 = r; mwrt1 = w; addr1 = a; din1 = d;
    wait_ack(1, 1, 1'b0);
    check("busy1_in_ack", {31'd0, busy1}, 32'd1);
    #1 mrd1 = 1'b0; mwrt1 = 1'b0;
    @(negedge Clock);
    check("busy1_after", {31'd0, busy1}, 32'd0);
    @(posedge Clock); #1;
  endtask

  initial begin
    Reset = 1'b1;
    mrd0 = 1'b1; mwrt0 = 1'b0; addr0 = 32'd0; din0 = 32'd0;
    mrd1 = 1'b0; mwrt1 = 1'b0; addr1 = 32'd0; din1 = 32'd0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_ack", {31'd0, ack0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_err", {31'd0, err0}, 32'd0);
    check("rst_data", dr0, 32'd0);
    check("rst_stall_req", {31'd0, stall0}, 32'd1);
    mrd0 = 1'b0;
    #1 check("rst_stall_idle", {31'd0, stall0}, 32'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Basic write then read, plus seed mem[0]
    access0(1'b0, 1'b1, 32'h5, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    access0(1'b1, 1'b0, 32'h5, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    access0(1'b0, 1'b1, 32'h0, 32'h0BADF00D, 1'b0, 32'h0, 1'b0);

    // Back-to-back: write held through Ack, then read in the Ack cycle
    q0.push_back('{cyc + 3, 1'b0, 32'h0, 1'b0});
    mwrt0 = 1'b1; addr0 = 32'h1; din0 = 32'h11111111;
    wait_ack(0, 3, 1'b0);
    #1 mwrt0 = 1'b0; mrd0 = 1'b1;
    q0.push_back('{cyc + 3, 1'b1, 32'h11111111, 1'b0});
    wait_ack(0, 2, 1'b1);
    #1 mrd0 = 1'b0;
    @(posedge Clock); #1;

    // Reset in the middle of a pending write
    access0(1'b0, 1'b1, 32'h7, 32'h12345678, 1'b0, 32'h0, 1'b0);
    access0(1'b1, 1'b0, 32'h7, 32'h0, 1'b1, 32'h12345678, 1'b0);
    mwrt0 = 1'b1; addr0 = 32'h7; din0 = 32'hCAFEF00D;
    @(posedge Clock);
    @(negedge Clock);
    check("busy_before_rst", {31'd0, busy0}, 32'd1);
    Reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy0}, 32'd0);
    check("midrst_ack", {31'd0, ack0}, 32'd0);
    check("midrst_data", dr0, 32'd0);
    mwrt0 = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    @(posedge Clock); #1;
    access0(1'b1, 1'b0, 32'h7, 32'h0, 1'b1, 32'h12345678, 1'b0);

    // Simultaneous mrd & mwrt acts as a flagged write
    access0(1'b1, 1'b1, 32'h3, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b1);
    access0(1'b1, 1'b0, 32'h3, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0);

    // Out-of-range address
    access0(1'b0, 1'b1, 32'h100, 32'h99999999, 1'b0, 32'h0, 1'b1);
    access0(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1'b1);
    access0(1'b1, 1'b0, 32'h000, 32'h0, 1'b1, 32'h0BADF00D, 1'b0);

    // Zero wait-state instance
    access1(1'b0, 1'b1, 32'h20, 32'h13579BDF, 1'b0, 32'h0, 1'b0);
    access1(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h13579BDF, 1'b0);
    access1(1'b1, 1'b1, 32'h21, 32'h2468ACE0, 1'b0, 32'h0, 1'b1);
    access1(1'b1, 1'b0, 32'h21, 32'h0, 1'b1, 32'h2468ACE0, 1'b0);

    repeat (4) @(posedge Clock);
    #1;
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
